// File: rtl/demux_seq_pkg.sv
// Shared types, sizes and helpers for the demux select sequencer.
// Used by demux_select_sequencer and demux_seq_next_ch.
package demux_seq_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DRIVE  = 2'b01,
        FINISH = 2'b10
    } seq_state_t;

    // Lowest enabled channel; returns 0 for an empty mask.
    function automatic logic [SEL_W-1:0] first_ch(input logic [NUM_CH-1:0] mask);
        logic [SEL_W-1:0] ch;
        logic             found;
        ch    = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!found && mask[i]) begin
                ch    = SEL_W'(i);
                found = 1'b1;
            end
        end
        return ch;
    endfunction

endpackage

// File: rtl/demultiplexer_1_to_4_dataflow.sv
// 1-to-4 dataflow demultiplexer driven by demux_select_sequencer.
// Purely combinational; no glitch-free guarantee on output_lines.
module demultiplexer_1_to_4_dataflow (
    input  logic       in,
    input  logic [1:0] select_lines,
    output logic [3:0] output_lines
);

    assign output_lines = {4{in}} & (4'b0001 << select_lines);

endmodule

// File: rtl/demux_seq_next_ch.sv
// Next enabled channel above cur (wrapping to the lowest enabled one), and
// whether cur is the highest enabled channel.
module demux_seq_next_ch
    import demux_seq_pkg::*;
(
    input  logic [SEL_W-1:0]  cur,
    input  logic [NUM_CH-1:0] mask,
    output logic [SEL_W-1:0]  nxt,
    output logic              is_last
);

    logic found;

    always_comb begin
        nxt   = first_ch(mask);
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!found && mask[i] && (SEL_W'(i) > cur)) begin
                nxt   = SEL_W'(i);
                found = 1'b1;
            end
        end
        is_last = !found;
    end

endmodule

// File: rtl/demux_select_sequencer.sv
// Sweeps select_lines over the demux channels, holding each HOLD_CYCLES clocks.
// Optional channel mask: define DEMUX_SEQ_MASK_EN to add the ch_mask port.
module demux_select_sequencer
    import demux_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 20,
    parameter int unsigned CNT_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              continuous,
    input  logic              data_in,
    output logic              in,
    output logic [SEL_W-1:0]  select_lines,
    output logic              slot_strobe,
    output logic              busy,
    output logic              done
`ifdef DEMUX_SEQ_MASK_EN
    ,
    input  logic [NUM_CH-1:0] ch_mask
`endif
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d, nxt_sel;
    logic              in_q, in_d;
    logic              strobe_q, strobe_d;
    logic              is_last;
    logic              accept;
    logic [NUM_CH-1:0] start_mask;
    logic [NUM_CH-1:0] active_mask;

`ifdef DEMUX_SEQ_MASK_EN
    logic [NUM_CH-1:0] mask_q;

    assign start_mask  = ch_mask;
    assign active_mask = mask_q;

    // Mask is frozen at the accepting start so mid-sweep changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else if (accept) begin
            mask_q <= ch_mask;
        end
    end
`else
    assign start_mask  = '1;
    assign active_mask = '1;
`endif

    assign accept = (state_q == IDLE) && start && (start_mask != '0);

    demux_seq_next_ch u_next_ch (
        .cur     (sel_q),
        .mask    (active_mask),
        .nxt     (nxt_sel),
        .is_last (is_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            in_q     <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            in_q     <= in_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        in_d     = in_q;
        strobe_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = DRIVE;
                    sel_d    = first_ch(start_mask);
                    in_d     = data_in;
                    strobe_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    in_d    = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (is_last && !continuous) begin
                        state_d = FINISH;
                        sel_d   = '0;
                        in_d    = 1'b0;
                    end else begin
                        sel_d    = nxt_sel;
                        in_d     = data_in;
                        strobe_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                in_d    = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign in           = in_q;
    assign select_lines = sel_q;
    assign slot_strobe  = strobe_q;
    assign busy         = (state_q == DRIVE);
    assign done         = (state_q == FINISH);

endmodule
